// File: rtl/dmem_responder.sv
// dmem_responder: byte-masked data memory with wait states and a 2-deep in-order response buffer
module dmem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0001_0000,
  parameter int DEPTH_WORDS = 6144,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_mem_req_i,
  input  logic [63:0] data_mem_addr_i,
  input  logic        data_mem_wr_i,
  input  logic [63:0] data_mem_wr_data_i,
  input  logic [7:0]  data_mem_mask_i,
  output logic        data_mem_ready_o,
  output logic        resp_valid_o,
  output logic [63:0] resp_rd_data_o,
  input  logic        resp_ready_i
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'd8;
  logic [63:0] mem [DEPTH_WORDS];
  logic s1_v, s1_wr, s1_in;
  logic [IW-1:0] s1_idx;
  logic [63:0] s1_data;
  logic [7:0] s1_mask;
  logic [3:0] cnt;
  logic [63:0] fifo [2];
  logic wp, rp;
  logic [1:0] fcnt, outs;
  logic [63:0] off, rd_word;
  logic in_rng, accept, fire, pop;
  // addresses below the window wrap to huge offsets, so one compare covers both edges
  assign off = data_mem_addr_i - BASE_ADDR;
  assign in_rng = off < SPAN;
  assign fire = s1_v & (cnt == 4'd0);
  assign pop = resp_valid_o & resp_ready_i;
  assign data_mem_ready_o = (~s1_v | fire) & ((outs < 2'd2) | pop);
  assign accept = data_mem_req_i & data_mem_ready_o;
  assign resp_valid_o = fcnt != 2'd0;
  assign resp_rd_data_o = resp_valid_o ? fifo[rp] : '0;
  assign rd_word = (s1_in & ~s1_wr) ? mem[s1_idx] : '0;
  always_ff @(posedge clk)
    if (fire && s1_wr && s1_in)
      for (int b = 0; b < 8; b++)
        if (s1_mask[b]) mem[s1_idx][8*b +: 8] <= s1_data[8*b +: 8];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s1_v <= 1'b0;
      s1_wr <= 1'b0;
      s1_in <= 1'b0;
      s1_idx <= '0;
      s1_data <= '0;
      s1_mask <= '0;
      cnt <= '0;
      fifo <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      fcnt <= '0;
      outs <= '0;
    end else begin
      if (accept) begin
        s1_v <= 1'b1;
        s1_wr <= data_mem_wr_i;
        s1_in <= in_rng;
        s1_idx <= off[IW+2:3];
        s1_data <= data_mem_wr_data_i;
        s1_mask <= data_mem_mask_i;
        cnt <= 4'(WAIT_CYCLES);
      end else if (fire) s1_v <= 1'b0;
      else if (s1_v && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (fire) begin
        fifo[wp] <= rd_word;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      fcnt <= fcnt + 2'(fire) - 2'(pop);
      outs <= outs + 2'(accept) - 2'(pop);
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed traffic against a queue/array reference model, two wait-state configs
module tb_dmem_responder;
  localparam logic [63:0] WIN_LO = 64'h1_0000, WIN_HI = 64'h1_BFFF;
  logic clk = 0, resetn = 0, sel = 0;
  logic req = 0, wr = 0, rready = 0;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0] mask = '0;
  logic rdy0, rdy3, val0, val3;
  logic [63:0] rd0, rd3;
  logic ready, valid;
  logic [63:0] rdata;
  int n_chk = 0, n_pass = 0;
  logic [63:0] mdl [longint];
  logic [63:0] expq [$];
  longint words [$];
  always #5 clk = ~clk;
  dmem_responder dut0 (
    .clk(clk), .resetn(resetn), .data_mem_req_i(req & ~sel), .data_mem_addr_i(addr),
    .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata), .data_mem_mask_i(mask),
    .data_mem_ready_o(rdy0), .resp_valid_o(val0), .resp_rd_data_o(rd0), .resp_ready_i(rready & ~sel)
  );
  dmem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .resetn(resetn), .data_mem_req_i(req & sel), .data_mem_addr_i(addr),
    .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata), .data_mem_mask_i(mask),
    .data_mem_ready_o(rdy3), .resp_valid_o(val3), .resp_rd_data_o(rd3), .resp_ready_i(rready & sel)
  );
  assign ready = sel ? rdy3 : rdy0;
  assign valid = sel ? val3 : val0;
  assign rdata = sel ? rd3 : rd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic longint key(input logic [63:0] a);
    return (sel ? (longint'(1) << 40) : longint'(0)) + longint'((a - WIN_LO) >> 3);
  endfunction

  // reference model: each accepted request is resolved immediately in acceptance order
  always @(negedge clk) begin
    logic inr;
    longint k;
    logic [63:0] old;
    if (resetn) begin
      if (req && ready) begin
        inr = addr >= WIN_LO && addr <= WIN_HI;
        k = key(addr);
        if (!wr) expq.push_back((inr && mdl.exists(k)) ? mdl[k] : 64'd0);
        else begin
          expq.push_back(64'd0);
          if (inr) begin
            old = mdl.exists(k) ? mdl[k] : 64'd0;
            for (int b = 0; b < 8; b++) if (mask[b]) old[8*b +: 8] = wdata[8*b +: 8];
            mdl[k] = old;
          end
        end
      end
      if (valid && rready) begin
        if (expq.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
        else check("resp_data", rdata, expq.pop_front());
      end
    end
  end

  task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    int n = 0;
    @(posedge clk); #1;
    req = 1; wr = w; addr = a; wdata = d; mask = m;
    @(negedge clk);
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req = 0;
  endtask

  task automatic lat_check(input int w);
    for (int i = 0; i <= w; i++) begin @(negedge clk); check("lat_idle", 64'(valid), 64'd0); end
    @(negedge clk); check("lat_valid", 64'(valid), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    rready = 1;
    while (expq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int acc;
    logic [63:0] held;
    longint w, r;
    #22;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data", rdata, 64'd0);
    @(negedge clk); resetn = 1;
    rready = 1;
    send(1, 64'h1_0000, 64'h1122_3344_5566_7788, 8'hFF);
    lat_check(0);
    check("wr_resp", rdata, 64'd0);
    send(0, 64'h1_0000, 64'd0, 8'h00);
    lat_check(0);
    check("rd_resp", rdata, 64'h1122_3344_5566_7788);
    send(1, 64'h1_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    send(1, 64'h1_000F, 64'h0000_00AB_0000_0000, 8'h10);
    drain();
    send(0, 64'h1_0008, 64'd0, 8'hFF);
    lat_check(0);
    check("mask_merge", rdata, 64'hFFFF_FFAB_FFFF_FFFF);
    drain();
    // backpressure: only two accepts with nothing popped
    @(posedge clk); #1;
    rready = 0; acc = 0;
    req = 1; wr = 0; addr = 64'h1_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(ready), (i < 2) ? 64'd1 : 64'd0);
      if (ready) acc++;
    end
    @(posedge clk); #1; req = 0;
    check("bp_accepts", 64'(acc), 64'd2);
    @(negedge clk); held = rdata;
    @(negedge clk);
    check("bp_valid_hold", 64'(valid), 64'd1);
    check("bp_data_hold", rdata, held);
    drain();
    // streaming with random words, one accept per cycle
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        w = longint'($urandom_range(0, 6143));
        req = 1; wr = 1; addr = WIN_LO + 64'(w) * 8; wdata = {$urandom, $urandom};
        mask = mdl.exists(key(addr)) ? 8'($urandom) : 8'hFF;
        words.push_back(w);
      end else begin
        r = words[$urandom_range(0, words.size() - 1)];
        req = 1; wr = 0; addr = WIN_LO + 64'(r) * 8 + 64'($urandom_range(0, 7));
      end
      @(negedge clk); check("stream_ready", 64'(ready), 64'd1);
      @(posedge clk); #1;
    end
    req = 0;
    drain();
    // three wait states on the second instance
    sel = 1;
    send(1, 64'h1_BFF8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    send(1, 64'h1_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    drain();
    send(0, 64'h1_BFF8, 64'd0, 8'h00);
    lat_check(3);
    check("last_word", rdata, 64'hDEAD_BEEF_0BAD_F00D);
    drain();
    send(0, 64'h1_C000, 64'd0, 8'h00);
    lat_check(3);
    check("oor_read", rdata, 64'd0);
    send(1, 64'h0_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    send(0, 64'h1_0000, 64'd0, 8'h00);
    send(0, 64'h1_BFF8, 64'd0, 8'h00);
    drain();
    // reset with two responses pending
    sel = 0; rready = 0;
    send(0, 64'h1_0008, 64'd0, 8'h00);
    send(0, 64'h1_0000, 64'd0, 8'h00);
    @(negedge clk); @(negedge clk);
    check("pre_rst_valid", 64'(valid), 64'd1);
    #2 resetn = 0;
    #1;
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_data", rdata, 64'd0);
    expq.delete();
    @(negedge clk); resetn = 1;
    rready = 1;
    send(0, 64'h1_0000, 64'd0, 8'h00);
    lat_check(0);
    check("post_rst_read", rdata, 64'h1122_3344_5566_7788);
    send(0, 64'h1_0008, 64'd0, 8'h00);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
